// File: rtl/monitoreo_pkg.sv
// Shared types and default parameters for the multichannel temperature monitor.
package monitoreo_pkg;

  localparam int unsigned NCH_DEF      = 4;
  localparam int unsigned W_DEF        = 11;
  localparam int unsigned N_PERS_DEF   = 5;
  localparam int          HYST_DEF     = 20;
  localparam int          TEMP_MIN_DEF = -400;
  localparam int          TEMP_MAX_DEF = 1000;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    FRIO     = 2'b01,
    CALIENTE = 2'b10,
    FALLA    = 2'b11
  } estado_t;

  // CLS_NINGUNO covers samples inside a hysteresis band (no class of interest)
  typedef enum logic [2:0] {
    CLS_NINGUNO = 3'd0,
    CLS_RETORNO = 3'd1,
    CLS_BAJO    = 3'd2,
    CLS_ALTO    = 3'd3,
    CLS_FUERA   = 3'd4
  } clase_t;

endpackage

// File: rtl/monitor_canal.sv
// One sensor channel: sample classifier, persistence counter and thermostat FSM.
module monitor_canal
  import monitoreo_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned N_PERS   = N_PERS_DEF,
  parameter int          HYST     = HYST_DEF,
  parameter int          TEMP_MIN = TEMP_MIN_DEF,
  parameter int          TEMP_MAX = TEMP_MAX_DEF
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic signed [W-1:0] temp,
  input  logic                valido,
  input  logic                limpiar,
  input  logic                congelar,
  input  logic                borrar,
  input  logic signed [W-1:0] umbral_bajo,
  input  logic signed [W-1:0] umbral_alto,
  output logic                calefactor,
  output logic                ventilador,
  output logic                alerta,
  output estado_t             estado
);

  localparam int unsigned CW = $clog2(N_PERS + 1);
  localparam int unsigned XW = W + 2;
  localparam logic [CW-1:0]        CNT_MAX = CW'(N_PERS);
  localparam logic signed [XW-1:0] LIM_MIN = XW'(TEMP_MIN);
  localparam logic signed [XW-1:0] LIM_MAX = XW'(TEMP_MAX);
  localparam logic signed [XW-1:0] HYST_X  = XW'(HYST);

  logic signed [XW-1:0] t_x, bajo_x, alto_x, ret_lo, ret_hi;
  clase_t               clase, clase_q, clase_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_run;
  estado_t              estado_d;
  logic                 cal_d, ven_d, ale_d;

  // Widened operands so threshold +/- hysteresis cannot wrap
  assign t_x    = XW'(temp);
  assign bajo_x = XW'(umbral_bajo);
  assign alto_x = XW'(umbral_alto);
  assign ret_lo = bajo_x + HYST_X;
  assign ret_hi = alto_x - HYST_X;

  always_comb begin
    clase = CLS_NINGUNO;
    if (t_x < LIM_MIN || t_x > LIM_MAX) clase = CLS_FUERA;
    else if (t_x > alto_x)              clase = CLS_ALTO;
    else if (t_x < bajo_x)              clase = CLS_BAJO;
    else if (t_x >= ret_lo && t_x <= ret_hi) clase = CLS_RETORNO;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado     <= NORMAL;
      clase_q    <= CLS_NINGUNO;
      cnt_q      <= '0;
      calefactor <= 1'b0;
      ventilador <= 1'b0;
      alerta     <= 1'b0;
    end else begin
      estado     <= estado_d;
      clase_q    <= clase_d;
      cnt_q      <= cnt_d;
      calefactor <= cal_d;
      ventilador <= ven_d;
      alerta     <= ale_d;
    end
  end

  // Next state and run counter; any state change restarts persistence
  always_comb begin
    estado_d = estado;
    clase_d  = clase_q;
    cnt_d    = cnt_q;
    cnt_run  = cnt_q;
    if (clase != clase_q)   cnt_run = CW'(1);
    else if (cnt_q != CNT_MAX) cnt_run = cnt_q + CW'(1);

    if (limpiar) begin
      estado_d = NORMAL;
      cnt_d    = '0;
    end else if (valido && !congelar) begin
      clase_d = clase;
      cnt_d   = cnt_run;
      if (estado == FALLA) begin
        if (borrar && clase != CLS_FUERA) estado_d = NORMAL;
      end else if (cnt_run == CNT_MAX) begin
        case (clase)
          CLS_FUERA:   estado_d = FALLA;
          CLS_ALTO:    estado_d = CALIENTE;
          CLS_BAJO:    estado_d = FRIO;
          CLS_RETORNO: estado_d = NORMAL;
          default:     estado_d = estado;
        endcase
      end
      if (estado_d != estado) cnt_d = '0;
    end
  end

  always_comb begin
    cal_d = (estado_d == FRIO);
    ven_d = (estado_d == CALIENTE);
    ale_d = (estado_d == FALLA);
  end

endmodule

// File: rtl/monitoreo_multicanal.sv
// Multichannel monitor top: threshold sanity flag, channel gating and global alert.
module monitoreo_multicanal
  import monitoreo_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned N_PERS   = N_PERS_DEF,
  parameter int          HYST     = HYST_DEF,
  parameter int          TEMP_MIN = TEMP_MIN_DEF,
  parameter int          TEMP_MAX = TEMP_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NCH-1:0][W-1:0]    temp_entrada,
  input  logic [NCH-1:0]           temp_valido,
  input  logic [NCH-1:0]           habilitar,
  input  logic signed [W-1:0]      umbral_bajo,
  input  logic signed [W-1:0]      umbral_alto,
  input  logic [NCH-1:0]           borrar_falla,
  output logic [NCH-1:0]           calefactor,
  output logic [NCH-1:0]           ventilador,
  output logic [NCH-1:0]           alerta,
  output logic [NCH-1:0][1:0]      estado_actual,
  output logic                     alerta_global,
  output logic                     error_config
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) error_config <= 1'b0;
    else         error_config <= (umbral_bajo >= umbral_alto);
  end

  // OR of registered flags only, so no input reaches it combinationally
  assign alerta_global = |alerta;

  for (genvar i = 0; i < NCH; i++) begin : g_canal
    monitor_canal #(
      .W        (W),
      .N_PERS   (N_PERS),
      .HYST     (HYST),
      .TEMP_MIN (TEMP_MIN),
      .TEMP_MAX (TEMP_MAX)
    ) u_canal (
      .clk         (clk),
      .arst_n      (arst_n),
      .temp        (temp_entrada[i]),
      .valido      (temp_valido[i]),
      .limpiar     (!habilitar[i]),
      .congelar    (error_config),
      .borrar      (borrar_falla[i]),
      .umbral_bajo (umbral_bajo),
      .umbral_alto (umbral_alto),
      .calefactor  (calefactor[i]),
      .ventilador  (ventilador[i]),
      .alerta      (alerta[i]),
      .estado      (estado_actual[i])
    );
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed and randomized checks of monitoreo_multicanal against a sample-history model.
module tb_monitoreo_multicanal;

  localparam int NCH  = 4;
  localparam int W    = 11;
  localparam int NP   = 5;
  localparam int HY   = 20;
  localparam int TMIN = -400;
  localparam int TMAX = 1000;

  localparam int ST_NORMAL = 0, ST_FRIO = 1, ST_CALIENTE = 2, ST_FALLA = 3;
  localparam int K_NADA = 0, K_RETORNO = 1, K_BAJO = 2, K_ALTO = 3, K_FUERA = 4;

  logic                  clk;
  logic                  arst_n;
  logic [NCH-1:0][W-1:0] temp_entrada;
  logic [NCH-1:0]        temp_valido, habilitar, borrar_falla;
  logic signed [W-1:0]   umbral_bajo, umbral_alto;
  logic [NCH-1:0]        calefactor, ventilador, alerta;
  logic [NCH-1:0][1:0]   estado_actual;
  logic                  alerta_global, error_config;

  int tests = 0;
  int fails = 0;

  int m_est [NCH];
  int m_run [NCH];
  int m_cls [NCH];
  bit m_ec;

  monitoreo_multicanal #(
    .NCH(NCH), .W(W), .N_PERS(NP), .HYST(HY), .TEMP_MIN(TMIN), .TEMP_MAX(TMAX)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .temp_entrada  (temp_entrada),
    .temp_valido   (temp_valido),
    .habilitar     (habilitar),
    .umbral_bajo   (umbral_bajo),
    .umbral_alto   (umbral_alto),
    .borrar_falla  (borrar_falla),
    .calefactor    (calefactor),
    .ventilador    (ventilador),
    .alerta        (alerta),
    .estado_actual (estado_actual),
    .alerta_global (alerta_global),
    .error_config  (error_config)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clasificar(input int t, input int ub, input int ua);
    if (t < TMIN || t > TMAX) return K_FUERA;
    if (t > ua) return K_ALTO;
    if (t < ub) return K_BAJO;
    if (t >= ub + HY && t <= ua - HY) return K_RETORNO;
    return K_NADA;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_est[i] = ST_NORMAL;
      m_run[i] = 0;
      m_cls[i] = -1;
    end
    m_ec = 1'b0;
  endtask

  // One clock edge of the reference: run lengths of identical classes decide moves
  task automatic model_step();
    int t, c, tgt;
    for (int i = 0; i < NCH; i++) begin
      if (!habilitar[i]) begin
        m_est[i] = ST_NORMAL;
        m_run[i] = 0;
      end else if (!m_ec && temp_valido[i]) begin
        t = int'($signed(temp_entrada[i]));
        c = clasificar(t, int'(umbral_bajo), int'(umbral_alto));
        m_run[i] = (c == m_cls[i]) ? m_run[i] + 1 : 1;
        m_cls[i] = c;
        if (m_est[i] == ST_FALLA) begin
          if (borrar_falla[i] && c != K_FUERA) begin
            m_est[i] = ST_NORMAL;
            m_run[i] = 0;
          end
        end else if (m_run[i] == NP) begin
          case (c)
            K_FUERA:   tgt = ST_FALLA;
            K_ALTO:    tgt = ST_CALIENTE;
            K_BAJO:    tgt = ST_FRIO;
            K_RETORNO: tgt = ST_NORMAL;
            default:   tgt = m_est[i];
          endcase
          if (tgt != m_est[i]) begin
            m_est[i] = tgt;
            m_run[i] = 0;
          end
        end
      end
    end
    m_ec = (umbral_bajo >= umbral_alto);
  endtask

  task automatic check_model();
    logic [NCH-1:0][1:0] e_est;
    logic [NCH-1:0]      e_cal, e_ven, e_ale;
    for (int i = 0; i < NCH; i++) begin
      e_est[i] = 2'(m_est[i]);
      e_cal[i] = (m_est[i] == ST_FRIO);
      e_ven[i] = (m_est[i] == ST_CALIENTE);
      e_ale[i] = (m_est[i] == ST_FALLA);
    end
    chk("estado", 32'(estado_actual), 32'(e_est));
    chk("calefactor", 32'(calefactor), 32'(e_cal));
    chk("ventilador", 32'(ventilador), 32'(e_ven));
    chk("alerta", 32'(alerta), 32'(e_ale));
    chk("alerta_global", 32'(alerta_global), 32'(|e_ale));
    chk("error_config", 32'(error_config), 32'(m_ec));
    chk("cal_y_ven", 32'(calefactor & ventilador), 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic chk_ceros(input string tag);
    chk({tag, "_estado"}, 32'(estado_actual), 32'd0);
    chk({tag, "_cal"}, 32'(calefactor), 32'd0);
    chk({tag, "_ven"}, 32'(ventilador), 32'd0);
    chk({tag, "_ale"}, 32'(alerta), 32'd0);
    chk({tag, "_glob"}, 32'(alerta_global), 32'd0);
    chk({tag, "_errcfg"}, 32'(error_config), 32'd0);
  endtask

  task automatic muestra(input int ch, input int t, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      temp_entrada[ch] = W'(t);
      temp_valido      = '0;
      temp_valido[ch]  = 1'b1;
      tick();
      if (gap) begin
        temp_valido = '0;
        tick();
      end
    end
    temp_valido = '0;
  endtask

  function automatic int pick(input int ub, input int ua);
    int t;
    case ($urandom_range(0, 4))
      0:       t = int'($urandom_range(0, 2047)) - 1024;
      1:       t = ua + int'($urandom_range(0, 60)) - 30;
      2:       t = ub + int'($urandom_range(0, 60)) - 30;
      3:       t = (ub + ua) / 2;
      default: t = TMAX + int'($urandom_range(0, 40)) - 10;
    endcase
    if (t > 1023)  t = 1023;
    if (t < -1024) t = -1024;
    return t;
  endfunction

  initial begin
    arst_n       = 1'b0;
    temp_entrada = '0;
    temp_valido  = '0;
    habilitar    = '1;
    borrar_falla = '0;
    umbral_bajo  = 11'sd0;
    umbral_alto  = 11'sd300;
    #2;
    chk_ceros("reset");
    model_reset();
    #10 arst_n = 1'b1;

    // Hot persistence on channel 0
    muestra(0, 350, 4, 1'b0);
    chk("hot_4_muestras", 32'(estado_actual[0]), 32'd0);
    muestra(0, 350, 1, 1'b0);
    chk("hot_5_estado", 32'(estado_actual[0]), 32'h2);
    chk("hot_5_ventilador", 32'(ventilador[0]), 32'd1);

    // Inside the hysteresis band nothing moves; below it, return to normal
    muestra(0, 290, 10, 1'b0);
    chk("banda_histeresis", 32'(estado_actual[0]), 32'h2);
    muestra(0, 270, 4, 1'b0);
    chk("retorno_4", 32'(estado_actual[0]), 32'h2);
    muestra(0, 270, 1, 1'b0);
    chk("retorno_5", 32'(estado_actual[0]), 32'd0);

    // Interrupted cold run on channel 1, with valid gaps between samples
    muestra(1, -100, 3, 1'b1);
    muestra(1, 50, 1, 1'b1);
    muestra(1, -100, 4, 1'b1);
    chk("frio_4_tras_corte", 32'(estado_actual[1]), 32'd0);
    muestra(1, -100, 1, 1'b1);
    chk("frio_5_estado", 32'(estado_actual[1]), 32'h1);
    chk("frio_5_calefactor", 32'(calefactor[1]), 32'd1);

    // Out-of-range fault and its clear conditions on channel 2
    muestra(2, 1023, 5, 1'b0);
    chk("falla_alerta", 32'(alerta[2]), 32'd1);
    chk("falla_global", 32'(alerta_global), 32'd1);
    borrar_falla[2] = 1'b1;
    muestra(2, 1023, 1, 1'b0);
    chk("borrar_fuera_rango", 32'(estado_actual[2]), 32'h3);
    muestra(2, 200, 1, 1'b0);
    chk("borrar_valido", 32'(estado_actual[2]), 32'd0);
    borrar_falla = '0;

    // Inverted thresholds freeze every channel
    muestra(0, 350, 5, 1'b0);
    umbral_bajo = 11'sd500;
    umbral_alto = 11'sd300;
    tick();
    chk("error_config_alto", 32'(error_config), 32'd1);
    muestra(0, 270, 6, 1'b0);
    chk("congelado_ch0", 32'(estado_actual[0]), 32'h2);
    chk("congelado_ch1", 32'(estado_actual[1]), 32'h1);
    umbral_bajo = 11'sd0;
    umbral_alto = 11'sd300;
    tick();
    chk("error_config_bajo", 32'(error_config), 32'd0);

    // Reset mid-run discards partial persistence
    muestra(3, 350, 3, 1'b0);
    arst_n = 1'b0;
    #2;
    chk_ceros("reset_medio");
    model_reset();
    #2 arst_n = 1'b1;
    muestra(3, 350, 4, 1'b0);
    chk("tras_reset_4", 32'(estado_actual[3]), 32'd0);
    muestra(3, 350, 1, 1'b0);
    chk("tras_reset_5", 32'(estado_actual[3]), 32'h2);

    // Disabling a channel forces it back to normal
    habilitar[3] = 1'b0;
    tick();
    chk("deshabilitar", 32'(estado_actual[3]), 32'd0);
    habilitar = '1;
    tick();

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin umbral_bajo = 11'sd0;   umbral_alto = 11'sd300; end
          1:       begin umbral_bajo = -11'sd50; umbral_alto = 11'sd200; end
          default: begin umbral_bajo = 11'sd500; umbral_alto = 11'sd300; end
        endcase
      end
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 7) == 0)
          temp_entrada[i] = W'(pick(int'(umbral_bajo), int'(umbral_alto)));
        temp_valido[i]  = ($urandom_range(0, 3) != 0);
        borrar_falla[i] = ($urandom_range(0, 15) == 0);
        habilitar[i]    = ($urandom_range(0, 31) != 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/monitoreo_multicanal.md
MONITOREO_MULTICANAL -- requirements
Module: monitoreo_multicanal

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent sensor channels (1..16).
REQ-002 SHALL have parameter W, default 11: signed temperature width, 0.1 °C per LSB.
REQ-003 SHALL have parameter N_PERS, default 5: consecutive qualifying samples required for any transition (1..15).
REQ-004 SHALL have parameter HYST, default 20: exit hysteresis in LSB, with HYST >= 0.
REQ-005 SHALL have parameters TEMP_MIN, default -400, and TEMP_MAX, default 1000: valid sensor range in LSB.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port temp_entrada, input, NCH x W signed: per-channel temperature.
REQ-009 SHALL have port temp_valido, input, NCH bits: per-channel sample strobe; a sample counts only when its bit is high.
REQ-010 SHALL have port habilitar, input, NCH bits: channel enable.
REQ-011 SHALL have ports umbral_bajo and umbral_alto, input, W signed each: runtime thresholds shared by all channels.
REQ-012 SHALL have port borrar_falla, input, NCH bits: per-channel fault-clear request.
REQ-013 SHALL have ports calefactor, ventilador and alerta, output, NCH bits each: per-channel actuators and fault flag.
REQ-014 SHALL have port estado_actual, output, NCH x 2: per-channel state encoding.
REQ-015 SHALL have port alerta_global, output, 1 bit: OR of all alerta bits.
REQ-016 SHALL have port error_config, output, 1 bit: registered flag, high while umbral_bajo >= umbral_alto.

Function
REQ-017 SHALL run one FSM per channel with states NORMAL=00, FRIO=01, CALIENTE=10, FALLA=11.
REQ-018 SHALL classify each valid sample into exactly one class, in this priority: fuera (outside [TEMP_MIN,TEMP_MAX]) > alto (> umbral_alto) > bajo (< umbral_bajo) > retorno.
REQ-019 SHALL define retorno as umbral_bajo+HYST <= temp <= umbral_alto-HYST, with comparisons evaluated in W+2 signed bits to avoid overflow.
REQ-020 SHALL keep one saturating run counter per channel, ceil(log2(N_PERS+1)) bits wide, that counts consecutive valid samples of the same class.
REQ-021 SHALL reset the run counter to 1 when a valid sample's class differs from the previous valid sample's class.
REQ-022 SHALL leave the run counter unchanged on cycles where temp_valido is low.
REQ-023 SHALL take a transition on the same edge that registers the N_PERS-th consecutive qualifying sample, then clear the run counter.
REQ-024 SHALL use these transitions: NORMAL->CALIENTE on alto; NORMAL->FRIO on bajo; FRIO->NORMAL and CALIENTE->NORMAL on retorno.
REQ-025 SHALL also allow FRIO->CALIENTE on alto and CALIENTE->FRIO on bajo.
REQ-026 SHALL move any state to FALLA on fuera.
REQ-027 SHALL leave FALLA only to NORMAL, only on an edge where borrar_falla is high and the current sample is valid and in range; borrar_falla SHALL be ignored in every other state.
REQ-028 SHALL drive calefactor=(FRIO), ventilador=(CALIENTE), alerta=(FALLA) as registered outputs decoded from the state register, with no combinational input->output path.
REQ-029 SHALL never assert calefactor and ventilador together on a channel.
REQ-030 SHALL, when habilitar[i]=0, force channel i to NORMAL and clear its counter on the next edge; when error_config=1, all channels SHALL hold state and counters.

Reset
REQ-031 SHALL, while arst_n=0, asynchronously force all states to NORMAL, all counters and class registers to 0, and all outputs to 0.
REQ-032 SHALL resume classification on the first edge after arst_n deasserts; a reset mid-run SHALL discard partial persistence.

Structure
REQ-033 SHALL place the estado_t enum, the class enum and the default parameter constants in package monitoreo_pkg.
REQ-034 SHALL implement per-channel logic (classifier, counter, FSM) in sub-module monitor_canal, instantiated NCH times via generate.
REQ-035 SHALL keep the top limited to error_config, alerta_global and enable/config gating.

Verification
REQ-036 Bench SHALL check: ch0 temp=350, umbral_alto=300, 5 consecutive valid samples -> ventilador[0]=1 after the 5th edge and estado=10; after only 4 samples -> still 00.
REQ-037 Bench SHALL check: in CALIENTE, temp=290 (inside the 20-LSB hysteresis band), 10 samples -> stays 10; then temp=270, 5 samples -> 00.
REQ-038 Bench SHALL check: temp=-100 with umbral_bajo=0, 3 samples; then 1 sample at 50; then 5 samples at -100 -> FRIO only on the final 5th sample; temp_valido gaps do not break the run.
REQ-039 Bench SHALL check: temp=1023, 5 samples -> alerta=1 and alerta_global=1; borrar_falla with temp=1023 -> stays 11; borrar_falla with temp=200 valid -> 00.
REQ-040 Bench SHALL check: umbral_bajo=500, umbral_alto=300 -> error_config=1 and states frozen; arst_n pulsed low mid-run -> all outputs 0 immediately.
